// File: rtl/seg7_pkg.sv
// Purpose : shared constants and types for the 7-segment scan capture block.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: active-low segment patterns (SSeg[0]=a .. SSeg[6]=g), frame FSM encoding,
//           decoded-digit struct.
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_A     = 7'b0001000;
  localparam logic [0:6] SEG_B     = 7'b1100000;
  localparam logic [0:6] SEG_C     = 7'b0110001;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_F     = 7'b0111000;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] nib;
    logic       minus;
    logic       blank;
    logic       err;
  } dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Purpose : map one active-low segment pattern to {nibble, minus, blank, err}.
// Latency : combinational.
// Backpr. : none; pure function of the input.
// Ports   : seg_i pattern (SSeg[0:6]), dec_o decoded digit.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (seg_i)
      SEG_0:     dec_o.nib = 4'h0;
      SEG_1:     dec_o.nib = 4'h1;
      SEG_2:     dec_o.nib = 4'h2;
      SEG_3:     dec_o.nib = 4'h3;
      SEG_4:     dec_o.nib = 4'h4;
      SEG_5:     dec_o.nib = 4'h5;
      SEG_6:     dec_o.nib = 4'h6;
      SEG_7:     dec_o.nib = 4'h7;
      SEG_8:     dec_o.nib = 4'h8;
      SEG_9:     dec_o.nib = 4'h9;
      SEG_A:     dec_o.nib = 4'hA;
      SEG_B:     dec_o.nib = 4'hB;
      SEG_C:     dec_o.nib = 4'hC;
      SEG_D:     dec_o.nib = 4'hD;
      SEG_E:     dec_o.nib = 4'hE;
      SEG_F:     dec_o.nib = 4'hF;
      SEG_MINUS: dec_o.minus = 1'b1;
      SEG_BLANK: dec_o.blank = 1'b1;
      default:   dec_o.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Purpose : receive side of a multiplexed 7-seg display; captures each digit once it has
//           dwelt STABLE_CYC samples and publishes a coherent 4-digit frame.
// Latency : 2-cycle input synchroniser; frame published 1 cycle after the 4th distinct capture.
// Backpr. : none; the display source cannot be stalled, frames are dropped on timeout.
// Ports   : clk, rst_n (async active-low); an/SSeg active-low display buses;
//           digits/minus/blank/err published frame, frame_valid strobe, stale timeout flag.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [0:6]  SSeg,
  output logic [15:0] digits,
  output logic [3:0]  minus,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [7:0]    ST_MAX = 8'(STABLE_CYC);

  logic [3:0]    an_s1_q, an_s2_q;
  logic [0:6]    seg_s1_q, seg_s2_q;
  logic [10:0]   prev_q;
  logic [7:0]    cnt_q, cnt_d;
  logic          cap_q, cap_d;
  logic [TW-1:0] idle_q, idle_d;
  state_e        state_q, state_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   sh_dig_q;
  logic [3:0]    sh_minus_q, sh_blank_q, sh_err_q;
  logic [15:0]   digits_q;
  logic [3:0]    minus_q, blank_q, err_q;
  logic          fv_q, stale_q;

  logic [3:0]  sel_oh;
  logic [10:0] sample;
  logic        sample_vld, same, capture, timeout, publish, set_stale;
  dec_t        dec;

  // A valid sample has exactly one anode low; the inverted bus is then the digit one-hot.
  assign sel_oh     = ~an_s2_q;
  assign sample     = {an_s2_q, seg_s2_q};
  assign sample_vld = (sel_oh != 4'h0) && ((sel_oh & 4'(sel_oh - 4'd1)) == 4'h0);
  assign same       = (sample == prev_q);

  seg7_pattern_decode u_dec (
    .seg_i (seg_s2_q),
    .dec_o (dec)
  );

  always_comb begin
    cnt_d = 8'd1;
    if (sample_vld && same) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : 8'(cnt_q + 8'd1);
    end
    // cap_q only means "this dwell already captured" while the sample is unchanged.
    capture = sample_vld && (cnt_d >= ST_MAX) && !(same && cap_q);
    cap_d   = same && (cap_q || capture);
    idle_d  = capture ? '0 : ((idle_q == TO_MAX) ? idle_q : TW'(idle_q + 1'b1));
    timeout = (idle_q == TO_MAX);
  end

  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    publish   = 1'b0;
    set_stale = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (capture) begin
          // Capture beats a coincident timeout.
          seen_d  = seen_q | sel_oh;
          state_d = ((seen_q | sel_oh) == 4'hF) ? ST_PUBLISH : ST_COLLECT;
        end else if (timeout) begin
          set_stale = 1'b1;
          seen_d    = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_PUBLISH: begin
        publish = 1'b1;
        // A capture landing in the publish cycle starts the next frame rather than being lost.
        seen_d  = capture ? sel_oh : 4'h0;
        state_d = capture ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        seen_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      idle_q     <= '0;
      state_q    <= ST_IDLE;
      seen_q     <= '0;
      sh_dig_q   <= '0;
      sh_minus_q <= '0;
      sh_blank_q <= 4'hF;
      sh_err_q   <= '0;
      digits_q   <= '0;
      minus_q    <= '0;
      blank_q    <= 4'hF;
      err_q      <= '0;
      fv_q       <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= SSeg;
      seg_s2_q <= seg_s1_q;
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      idle_q   <= idle_d;
      state_q  <= state_d;
      seen_q   <= seen_d;
      for (int i = 0; i < 4; i++) begin
        if (capture && sel_oh[i]) begin
          sh_dig_q[4*i +: 4] <= dec.nib;
          sh_minus_q[i]      <= dec.minus;
          sh_blank_q[i]      <= dec.blank;
          sh_err_q[i]        <= dec.err;
        end
      end
      fv_q <= publish;
      if (publish) begin
        digits_q <= sh_dig_q;
        minus_q  <= sh_minus_q;
        blank_q  <= sh_blank_q;
        err_q    <= sh_err_q;
        stale_q  <= 1'b0;
      end else if (set_stale) begin
        stale_q  <= 1'b1;
      end
    end
  end

  assign digits      = digits_q;
  assign minus       = minus_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive end of the multiplexed 7-segment display interface: samples the active-low anode bus and the active-low segment bus, waits for each digit to hold stable, and decodes each segment pattern back to a hex nibble, minus sign or blank.
- Publishes a coherent 4-digit frame with a one-cycle valid strobe.
- Used for board-to-board loopback and as a self-check monitor beside the display driver.

Parameters:
- STABLE_CYC, 16: consecutive identical valid samples required before a digit is captured (range 2..255).
- TIMEOUT_CYC, 1000000: cycles without any capture before the partial frame is discarded and stale is raised.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- an  in  4  anode select, active-low one-hot; an[i]=0 selects digit i.
- SSeg  in  7 [0:6]  segments, active-low; SSeg[0]=a … SSeg[6]=g.
- digits  out  16  captured nibbles; digits[4i+3:4i] belongs to digit i.
- minus  out  4  minus[i]=1: digit i showed '-'.
- blank  out  4  blank[i]=1: digit i showed all segments off.
- err  out  4  err[i]=1: digit i showed an undecodable pattern.
- frame_valid  out  1  one-cycle strobe when outputs update.
- stale  out  1  set on timeout; cleared by the next frame_valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - digits=0, minus=0, blank=4'hF, err=0, frame_valid=0, stale=0.
  - All counters, masks and synchronisers are cleared.
- Input synchronisation:
  - an and SSeg pass through a 2-flop synchroniser, since the sources are asynchronous to clk.
  - Input-to-first-sample latency is 2 cycles.
- Sample classification, per synchronised {an, SSeg}:
  - Exactly one an bit low: VALID.
  - an=4'hF: GAP.
  - Anything else: ILLEGAL.
- Stability counter:
  - Increments on each VALID sample equal to the previous sample.
  - Reloads to 1 on any change of {an, SSeg}, on GAP, or on ILLEGAL.
  - When it reaches STABLE_CYC and the dwell is not yet captured, capture once and set the captured flag.
  - The captured flag clears when {an, SSeg} changes, so at most one capture per dwell.
- Decode (active-low patterns, SSeg[0:6]):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - '-'=1111110: nibble 0, minus=1.
  - 1111111: nibble 0, blank=1.
  - Any other pattern: nibble 0, err=1.
- Capture writes shadow registers for digit i: nibble, minus, blank, err. A repeat capture of a digit within the same frame overwrites its shadow entry without error.
- Frame FSM:
  - States: IDLE, COLLECT, PUBLISH.
  - IDLE → COLLECT on first capture; that capture sets seen_mask[i].
  - COLLECT: each capture ORs into seen_mask. When seen_mask=4'hF → PUBLISH.
  - PUBLISH (one cycle): copy all shadows to the outputs atomically, pulse frame_valid=1, clear stale, clear seen_mask → IDLE.
  - Outputs change only in PUBLISH, so latency is 1 cycle after the fourth distinct capture.
- Timeout:
  - Idle counter resets on every capture and saturates.
  - In COLLECT or IDLE, reaching TIMEOUT_CYC sets stale=1, clears seen_mask and returns to IDLE.
  - Published outputs are retained; stale stays set until the next frame_valid.
- Simultaneous events:
  - Capture and timeout in the same cycle: the capture wins and the counter resets.
  - Reset during COLLECT discards the partial frame.
- ILLEGAL samples (ghosting, multiple anodes low) are never captured and produce no error flag.

Decomposition:
- Shared package seg7_pkg holds:
  - the 18 segment pattern constants (0–F, minus, blank);
  - the FSM state encoding (IDLE, COLLECT, PUBLISH);
  - the SEG_BLANK constant.
- Natural sub-module seg7_pattern_decode: combinational 7-bit pattern → {nibble, minus, blank, err}.
- Everything else stays in seg7_scan_capture.

Test Plan:
- Scan "1","2","3","4" on digits 3..0, 20 cycles each, STABLE_CYC=16 → one frame_valid; digits=16'h1234, minus=0, blank=0, err=0.
- Digit 3 shows 1111110, digits 2..0 show "0","0","5" → digits=16'h0005, minus=4'b1000.
- Each digit held only 10 cycles → no capture, no frame_valid. Then hold 20 cycles → frame published.
- Inject an=4'b0011 for 40 cycles mid-scan → no capture, err=0. The frame completes once legal scanning resumes.
- Digit 1 pattern 1010101 → err=4'b0010, nibble 0 for digit 1.
- Capture only digits 0 and 1, then stop for TIMEOUT_CYC (set to 100) → stale=1, outputs unchanged. The next full scan gives frame_valid=1 and stale=0.
- Assert rst_n=0 asynchronously mid-COLLECT → outputs return to reset values immediately; the first frame after release needs all four digits.
